// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter:
//   - FSM state type and encodings (IDLE, START, DATA, PARITY, STOP)
//   - parity-type constants (PAR_EVEN / PAR_ODD) matching the PAR_TYP input
//   - constant functions that derive the bit period in clock cycles and the
//     width of the counter that spans it
// -----------------------------------------------------------------------------
package uart_pkg;

  // State encodings are plain constants so that existing code comparing
  // against raw 3-bit values keeps working.
  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  // PAR_TYP encoding.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Clock cycles per serial bit. Integer division truncates, so the actual
  // bit rate is slightly above BAUD_RATE when the ratio is not exact.
  function automatic int calc_clk_ticks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of a counter spanning 0..ticks-1, never narrower than one bit.
  function automatic int calc_cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_tx_baud_counter
// Free-running bit-period counter for the UART transmitter. Counts
// 0..TICKS-1 and wraps; bit_done is high during the last cycle of each
// bit period, i.e. the cycle whose closing edge is the bit transition.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clear     in   hold the count at 0 (used while the transmitter idles)
//   bit_done  out  high in the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_tx_baud_counter
  import uart_pkg::*;
#(
  parameter int TICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int                CNT_W = calc_cnt_width(TICKS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] count;

  // NOTE: flops are updated with non-blocking (<=) so every register in the
  // design samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_done = (count == LAST) && !clear;

endmodule : uart_tx_baud_counter

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Accepts one P_data_width-bit word per request and sends
// it as: start bit (0), data LSB first, optional parity bit, stop bit (1).
// Each bit lasts CLK_Ticks = CLK_freq/BAUD_RATE clock cycles.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-low reset
//   PAR_EN      in   1 = append a parity bit after the data bits
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   P_data      in   word to transmit
//   DATA_VALID  in   transmit request (level); sampled only while idle
//   TX_OUT      out  serial line, idles high, registered
//   Busy        out  high for the whole frame, registered
//
// A request is taken on any edge in IDLE with DATA_VALID=1; the start bit
// and Busy appear on that same edge. After the stop bit the FSM always
// spends one cycle in IDLE, so a held DATA_VALID yields frames separated by
// exactly one idle clock.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_data_width      = 8,
  parameter int data_size_address = $clog2(P_data_width),
  parameter int BAUD_RATE         = 9600,
  parameter int CLK_freq          = 200_000_000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  input  logic [P_data_width-1:0] P_data,
  input  logic                    DATA_VALID,
  output logic                    TX_OUT,
  output logic                    Busy
);

  localparam int CLK_Ticks = calc_clk_ticks(CLK_freq, BAUD_RATE);
  localparam logic [data_size_address-1:0] LAST_IDX =
    data_size_address'(P_data_width - 1);

  state_t                       state;
  logic [P_data_width-1:0]      data_reg;
  logic                         par_en_reg;
  logic                         par_bit;
  logic [data_size_address-1:0] bit_idx;
  logic [data_size_address-1:0] idx_next;
  logic                         bit_done;
  logic                         baud_clear;

  // The bit-period counter only runs while a frame is in flight, so the
  // first period of every frame starts cleanly at count 0.
  assign baud_clear = (state == IDLE);
  assign idx_next   = bit_idx + 1'b1;

  uart_tx_baud_counter #(
    .TICKS (CLK_Ticks)
  ) u_baud (
    .clk      (CLK),
    .rst_n    (RST),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  // NOTE: TX_OUT and Busy are flops written inside the FSM block, so no
  // input can reach them through combinational logic.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      data_reg   <= '0;
      par_en_reg <= 1'b0;
      par_bit    <= 1'b0;
      bit_idx    <= '0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            // Word and parity settings are captured here and never looked
            // at again until the next request, so mid-frame input changes
            // cannot disturb the frame.
            data_reg   <= P_data;
            par_en_reg <= PAR_EN;
            par_bit    <= (PAR_TYP == PAR_EVEN) ? (^P_data) : ~(^P_data);
            bit_idx    <= '0;
            state      <= START;
            TX_OUT     <= 1'b0;
            Busy       <= 1'b1;
          end else begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            TX_OUT  <= data_reg[0];
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_reg) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_idx <= idx_next;
              TX_OUT  <= data_reg[idx_next];
            end
          end
        end

        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
        end

        STOP: begin
          // Line is already high; dropping Busy here leaves exactly one
          // IDLE cycle before a held request can start the next frame.
          if (bit_done) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx at 16 clock cycles per bit
// (CLK_freq = 16 MHz, BAUD_RATE = 1 Mbit/s). Expected frames are written out
// by hand as {stop, [parity], data, start} vectors, sent LSB first.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int TICKS = 16;

  logic       CLK        = 1'b0;
  logic       RST        = 1'b1;
  logic       PAR_EN     = 1'b0;
  logic       PAR_TYP    = 1'b0;
  logic [7:0] P_data     = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(
    .P_data_width (8),
    .BAUD_RATE    (1_000_000),
    .CLK_freq     (16_000_000)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_data     (P_data),
    .DATA_VALID (DATA_VALID),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present a request at a falling edge; it is accepted on the next rising
  // edge. Returns at the following falling edge, which is cycle 0 of the frame.
  task automatic request(input logic [7:0] d, input logic pe, input logic pt,
                         input logic hold);
    P_data     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    if (!hold) DATA_VALID = 1'b0;
  endtask

  // Starting at cycle 0 of a frame, check each bit at its first, middle and
  // last cycle, Busy throughout, then the idle cycle right after the frame.
  // With mangle set, all inputs are disturbed while data bit 2 is on the line.
  task automatic run_frame(input string name, input logic [10:0] exp_bits,
                           input int nbits, input logic mangle);
    for (int k = 0; k < nbits * TICKS; k++) begin
      int b = k / TICKS;
      int p = k % TICKS;
      if (p == 0 || p == TICKS / 2 || p == TICKS - 1)
        check($sformatf("%s tx bit%0d c%0d", name, b, p), 32'(TX_OUT), 32'(exp_bits[b]));
      if (p == 0 || p == TICKS - 1)
        check($sformatf("%s busy bit%0d c%0d", name, b, p), 32'(Busy), 32'd1);
      if (mangle && k == 3 * TICKS + 4) begin
        P_data     = 8'hFF;
        PAR_EN     = ~PAR_EN;
        PAR_TYP    = ~PAR_TYP;
        DATA_VALID = 1'b1;
      end
      if (mangle && k == 3 * TICKS + 6) DATA_VALID = 1'b0;
      @(negedge CLK);
    end
    check($sformatf("%s idle tx", name),   32'(TX_OUT), 32'd1);
    check($sformatf("%s idle busy", name), 32'(Busy),   32'd0);
  endtask

  initial begin
    // Power-on reset
    #2 RST = 1'b0;
    #1;
    check("por tx",   32'(TX_OUT), 32'd1);
    check("por busy", 32'(Busy),   32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge CLK);
      check($sformatf("idle tx %0d", i),   32'(TX_OUT), 32'd1);
      check($sformatf("idle busy %0d", i), 32'(Busy),   32'd0);
    end

    // 8'hA5, no parity: line 0,1,0,1,0,0,1,0,1,1 for 160 cycles
    request(8'hA5, 1'b0, 1'b0, 1'b0);
    run_frame("a5_nopar", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);

    // 8'hA5 even parity -> parity bit 0, 176 cycles
    request(8'hA5, 1'b1, 1'b0, 1'b0);
    run_frame("a5_even", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0);

    // 8'hA5 odd parity -> parity bit 1
    request(8'hA5, 1'b1, 1'b1, 1'b0);
    run_frame("a5_odd", {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0);

    // 8'h07 even parity -> three ones, parity bit 1
    request(8'h07, 1'b1, 1'b0, 1'b0);
    run_frame("07_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0);

    // DATA_VALID held: identical frames with a single idle cycle between
    request(8'hA5, 1'b0, 1'b0, 1'b1);
    run_frame("cont0", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);
    @(negedge CLK);
    run_frame("cont1", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);
    @(negedge CLK);
    run_frame("cont2", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);
    DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("after cont tx",   32'(TX_OUT), 32'd1);
    check("after cont busy", 32'(Busy),   32'd0);

    // Inputs disturbed mid-frame: frame still A5 with even parity
    request(8'hA5, 1'b1, 1'b0, 1'b0);
    run_frame("mangle", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b1);
    repeat (2) @(negedge CLK);
    check("after mangle busy", 32'(Busy), 32'd0);

    // Reset while data bit 3 (a 0 for A5) is on the line
    request(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (4 * TICKS + 5) @(negedge CLK);
    check("pre-reset tx",   32'(TX_OUT), 32'd0);
    check("pre-reset busy", 32'(Busy),   32'd1);
    DATA_VALID = 1'b1;
    #2 RST = 1'b0;
    #1;
    check("async reset tx",   32'(TX_OUT), 32'd1);
    check("async reset busy", 32'(Busy),   32'd0);
    repeat (3) @(negedge CLK);
    check("in reset tx",   32'(TX_OUT), 32'd1);
    check("in reset busy", 32'(Busy),   32'd0);
    RST = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    run_frame("post_reset", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx
